// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU core.
//   - opcode encodings (OP_NOP .. OP_MUL, OP_LAST marks the highest legal code)
//   - FSM state type
//   - width helper for the multiplier iteration counter
package alu_seq_pkg;

   localparam int unsigned OP_NOP  = 0;
   localparam int unsigned OP_ADD  = 1;
   localparam int unsigned OP_SUB  = 2;
   localparam int unsigned OP_NEG  = 3;
   localparam int unsigned OP_AND  = 4;
   localparam int unsigned OP_OR   = 5;
   localparam int unsigned OP_XOR  = 6;
   localparam int unsigned OP_NOT  = 7;
   localparam int unsigned OP_SHL  = 8;
   localparam int unsigned OP_SHR  = 9;
   localparam int unsigned OP_MUL  = 10;
   localparam int unsigned OP_LAST = 10;

   typedef enum logic [0:0] {
      IDLE,
      MUL
   } state_e;

   // Counter must be able to hold 0..width.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for one debounced button level.
//   clk_i    : system clock
//   level_i  : debounced button level
//   pulse_o  : high for the cycle in which level_i is high but was low at the previous edge
// The history register tracks level_i unconditionally, including while the
// core is in reset, so a button held across reset release yields no pulse.
module edge_pulse (
   input  logic clk_i,
   input  logic level_i,
   output logic pulse_o
);

   logic level_q;

   always_ff @(posedge clk_i) begin
      level_q <= level_i;
   end

   assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: push-button operand load / execute with registered
// operands, result and status flags, plus a shift-add multiplier.
//   clk_50M, rst        : clock, synchronous active-high reset
//   din, op             : operand and opcode switches
//   ld_a, ld_b, exec    : debounced button levels (acted on at rising edge)
//   result              : 2*WIDTH-bit registered result
//   flag_c/z/n/v        : carry, zero, negative, overflow
//   busy, done, err     : multiply in progress, update pulse, sticky illegal opcode
module alu_seq_core import alu_seq_pkg::*; #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned OPW   = 4
) (
   input  logic                 clk_50M,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     din,
   input  logic [OPW-1:0]       op,
   input  logic                 ld_a,
   input  logic                 ld_b,
   input  logic                 exec,
   output logic [2*WIDTH-1:0]   result,
   output logic                 flag_c,
   output logic                 flag_z,
   output logic                 flag_n,
   output logic                 flag_v,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int unsigned CntW = cnt_width(WIDTH);
   localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

   logic ld_a_ev, ld_b_ev, exec_ev;

   edge_pulse u_ld_a (.clk_i(clk_50M), .level_i(ld_a), .pulse_o(ld_a_ev));
   edge_pulse u_ld_b (.clk_i(clk_50M), .level_i(ld_b), .pulse_o(ld_b_ev));
   edge_pulse u_exec (.clk_i(clk_50M), .level_i(exec), .pulse_o(exec_ev));

   state_e               state_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [2*WIDTH-1:0]   result_q;
   logic                 c_q, z_q, n_q, v_q;
   logic                 busy_q, done_q, err_q;
   logic [2*WIDTH-1:0]   mcand_q, acc_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [CntW-1:0]      cnt_q;

   // Single-cycle ALU, evaluated on the current (pre-load) operands.
   logic [WIDTH:0]       sum_w;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c, alu_v;
   logic                 op_illegal;
   logic [2*WIDTH-1:0]   mul_acc_d;

   assign op_illegal = 32'(op) > OP_LAST;

   always_comb begin
      sum_w   = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OPW'(OP_ADD): begin
            sum_w   = {1'b0, a_q} + {1'b0, b_q};
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
         end
         OPW'(OP_SUB): begin
            // Extra top bit of the difference is the unsigned borrow.
            sum_w   = {1'b0, a_q} - {1'b0, b_q};
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
         end
         OPW'(OP_NEG): begin
            alu_res = -a_q;
            alu_c   = |a_q;
            alu_v   = (a_q == MinNeg);
         end
         OPW'(OP_AND): alu_res = a_q & b_q;
         OPW'(OP_OR):  alu_res = a_q | b_q;
         OPW'(OP_XOR): alu_res = a_q ^ b_q;
         OPW'(OP_NOT): alu_res = ~a_q;
         OPW'(OP_SHL): begin
            alu_res = {a_q[WIDTH-2:0], 1'b0};
            alu_c   = a_q[WIDTH-1];
         end
         OPW'(OP_SHR): begin
            alu_res = {1'b0, a_q[WIDTH-1:1]};
            alu_c   = a_q[0];
         end
         default: ;
      endcase
   end

   assign mul_acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Gating on done_q keeps an exec edge arriving right after a
               // multiply finishes from producing back-to-back done pulses.
               if (exec_ev && !done_q) begin
                  if (op_illegal) begin
                     err_q <= 1'b1;
                  end else if (op == OPW'(OP_MUL)) begin
                     mcand_q  <= {{WIDTH{1'b0}}, a_q};
                     mplier_q <= b_q;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= MUL;
                  end else if (op != OPW'(OP_NOP)) begin
                     result_q <= {{WIDTH{1'b0}}, alu_res};
                     c_q      <= alu_c;
                     z_q      <= (alu_res == '0);
                     n_q      <= alu_res[WIDTH-1];
                     v_q      <= alu_v;
                     done_q   <= 1'b1;
                  end
               end
               if (ld_a_ev) a_q <= din;
               if (ld_b_ev) b_q <= din;
            end
            MUL: begin
               acc_q    <= mul_acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  result_q <= mul_acc_d;
                  c_q      <= |mul_acc_d[2*WIDTH-1:WIDTH];
                  z_q      <= (mul_acc_d == '0);
                  n_q      <= 1'b0;
                  v_q      <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result = result_q;
   assign flag_c = c_q;
   assign flag_z = z_q;
   assign flag_n = n_q;
   assign flag_v = v_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;

   logic        clk_50M = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  din = '0;
   logic [3:0]  op = '0;
   logic        ld_a = 1'b0, ld_b = 1'b0, exec = 1'b0;
   logic [15:0] result;
   logic        flag_c, flag_z, flag_n, flag_v, busy, done, err;

   always #10 clk_50M = ~clk_50M;

   alu_seq_core #(.WIDTH(8), .OPW(4)) dut (
      .clk_50M(clk_50M), .rst(rst), .din(din), .op(op),
      .ld_a(ld_a), .ld_b(ld_b), .exec(exec),
      .result(result), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
      .flag_v(flag_v), .busy(busy), .done(done), .err(err)
   );

   int total = 0, bad = 0, done_cnt = 0, busy_cyc = 0;

   // ---------------- behavioural model ----------------
   bit          m_valid = 1'b0;
   int          m_a, m_b, m_busy_left;
   logic [15:0] m_res, m_prod;
   bit          m_c, m_z, m_n, m_v, m_done, m_nd, m_err;
   bit          pa, pb, pe;

   function automatic int to_signed8(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   function automatic bit ovf8(input int s);
      return (s > 127) || (s < -128);
   endfunction

   task automatic m_set(input int val, input bit c, input bit v);
      m_res = 16'(val);
      m_c = c; m_v = v;
      m_z = (val == 0);
      m_n = (val >= 128);
      m_nd = 1'b1;
   endtask

   task automatic model_exec(input int code);
      int a, b, sa, sb;
      a = m_a; b = m_b; sa = to_signed8(a); sb = to_signed8(b);
      case (code)
         0: ;
         1: m_set((a + b) % 256, (a + b) >= 256, ovf8(sa + sb));
         2: m_set((a - b + 256) % 256, a < b, ovf8(sa - sb));
         3: m_set((256 - a) % 256, a != 0, ovf8(-sa));
         4: m_set(a & b, 0, 0);
         5: m_set(a | b, 0, 0);
         6: m_set(a ^ b, 0, 0);
         7: m_set(255 - a, 0, 0);
         8: m_set((a * 2) % 256, a >= 128, 0);
         9: m_set(a / 2, (a % 2) == 1, 0);
         10: begin m_prod = 16'(a * b); m_busy_left = 8; end
         default: m_err = 1'b1;
      endcase
   endtask

   always @(posedge clk_50M) begin
      bit ea, eb, ee;
      ea = ld_a && !pa; eb = ld_b && !pb; ee = exec && !pe;
      pa = ld_a; pb = ld_b; pe = exec;
      if (rst) begin
         m_valid = 1'b1;
         m_a = 0; m_b = 0; m_busy_left = 0; m_res = '0;
         m_c = 0; m_z = 0; m_n = 0; m_v = 0; m_done = 0; m_err = 0;
      end else begin
         m_nd = 1'b0;
         if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
               m_res = m_prod; m_c = (m_prod >> 8) != 0; m_z = (m_prod == 0);
               m_n = 0; m_v = 0; m_nd = 1'b1;
            end
         end else begin
            if (ee && !m_done) model_exec(int'(op));
            if (ea) m_a = int'(din);
            if (eb) m_b = int'(din);
         end
         m_done = m_nd;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk_50M);
      if (m_valid) begin
         total++;
         if ({result, flag_c, flag_z, flag_n, flag_v, busy, done, err} !==
             {m_res, m_c, m_z, m_n, m_v, (m_busy_left > 0), m_done, m_err}) begin
            bad++;
            $display("FAIL model_cycle t=%0t actual res=%h cznv=%b%b%b%b busy=%b done=%b err=%b required res=%h cznv=%b%b%b%b busy=%b done=%b err=%b",
                     $time, result, flag_c, flag_z, flag_n, flag_v, busy, done, err,
                     m_res, m_c, m_z, m_n, m_v, (m_busy_left > 0), m_done, m_err);
         end
      end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cyc++;
   end

   // ---------------- directed stimulus ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_50M);
      #1;
   endtask

   task automatic load(input bit sel_b, input logic [7:0] v);
      din = v;
      if (sel_b) ld_b = 1'b1; else ld_a = 1'b1;
      tick(1);
      ld_a = 1'b0; ld_b = 1'b0;
      tick(1);
   endtask

   task automatic run_op(input logic [3:0] code, input string name,
                         input logic [15:0] exp_res, input logic [3:0] exp_f);
      int d0;
      d0 = done_cnt;
      op = code; exec = 1'b1;
      tick(1);
      check({name, "_done_hi"}, 32'(done), 32'd1);
      exec = 1'b0;
      tick(1);
      check({name, "_done_lo"}, 32'(done), 32'd0);
      check({name, "_res"}, 32'(result), 32'(exp_res));
      check({name, "_flags"}, 32'({flag_c, flag_z, flag_n, flag_v}), 32'(exp_f));
      check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic run_mul(input string name, input bit inject,
                          input logic [15:0] exp_res, input logic [3:0] exp_f);
      int d0, b0;
      bit seen;
      d0 = done_cnt; b0 = busy_cyc; seen = 1'b0;
      op = 4'd10; exec = 1'b1;
      tick(1);
      check({name, "_busy"}, 32'(busy), 32'd1);
      exec = 1'b0;
      tick(3);
      if (inject) begin
         exec = 1'b1; tick(1); exec = 1'b0;
      end
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin seen = 1'b1; break; end
         tick(1);
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      tick(2);
      check({name, "_res"}, 32'(result), 32'(exp_res));
      check({name, "_flags"}, 32'({flag_c, flag_z, flag_n, flag_v}), 32'(exp_f));
      check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
      check({name, "_busy_cycles"}, 32'(busy_cyc - b0), 32'd8);
   endtask

   initial begin
      int d0;
      tick(5);
      check("reset_state", 32'({result, flag_c, flag_z, flag_n, flag_v, busy, done, err}), 32'd0);
      rst = 1'b0;
      tick(1);

      // 1 / 2: single-cycle ops with A=0xFF, B=0x0F
      load(1'b0, 8'd255);
      load(1'b1, 8'd15);
      run_op(4'd1, "add", 16'h000E, 4'b1000);
      run_op(4'd2, "sub", 16'h00F0, 4'b0010);
      run_op(4'd3, "neg", 16'h0001, 4'b1000);
      run_op(4'd4, "and", 16'h000F, 4'b0000);
      run_op(4'd5, "or",  16'h00FF, 4'b0010);
      run_op(4'd6, "xor", 16'h00F0, 4'b0010);
      run_op(4'd7, "not", 16'h0000, 4'b0100);
      run_op(4'd8, "shl", 16'h00FE, 4'b1010);
      run_op(4'd9, "shr", 16'h007F, 4'b1000);

      // 3: multiply with an exec edge injected while busy
      run_mul("mul_ff_0f", 1'b1, 16'h0EF1, 4'b1000);

      // 4: exec held for 20 cycles -> one done
      d0 = done_cnt;
      op = 4'd1; exec = 1'b1;
      tick(20);
      exec = 1'b0;
      tick(2);
      check("held_exec_done_count", 32'(done_cnt - d0), 32'd1);
      check("held_exec_res", 32'(result), 32'h000E);

      // ld_a held through reset release -> A stays 0
      din = 8'hAA; ld_a = 1'b1; rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(3);
      ld_a = 1'b0;
      tick(1);
      load(1'b1, 8'd5);
      run_op(4'd1, "add_a_zero", 16'h0005, 4'b0000);

      // 5: illegal opcode
      d0 = done_cnt;
      op = 4'd12; exec = 1'b1;
      tick(1);
      exec = 1'b0;
      tick(2);
      check("illegal_err", 32'(err), 32'd1);
      check("illegal_res_kept", 32'(result), 32'h0005);
      check("illegal_no_done", 32'(done_cnt - d0), 32'd0);
      run_op(4'd7, "not_after_err", 16'h00FF, 4'b0010);
      check("err_sticky", 32'(err), 32'd1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("err_cleared", 32'(err), 32'd0);

      // 6: reset during a multiply
      load(1'b0, 8'd200);
      load(1'b1, 8'd3);
      op = 4'd10; exec = 1'b1;
      tick(1);
      exec = 1'b0;
      tick(3);
      check("mul_abort_busy_before", 32'(busy), 32'd1);
      d0 = done_cnt;
      rst = 1'b1;
      tick(1);
      check("mul_abort_busy", 32'(busy), 32'd0);
      check("mul_abort_res", 32'(result), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(12);
      check("mul_abort_no_done", 32'(done_cnt - d0), 32'd0);

      load(1'b0, 8'd12);
      load(1'b1, 8'd13);
      run_mul("mul_12_13", 1'b0, 16'h009C, 4'b0000);
      load(1'b0, 8'h7F);
      load(1'b1, 8'h01);
      run_op(4'd1, "add_ovf", 16'h0080, 4'b0011);
      load(1'b0, 8'h80);
      run_op(4'd3, "neg_min", 16'h0080, 4'b1011);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised sequential ALU core, the next generation of the board-level push-button ALU (switch operand entry, pb1/pb2/pb3 load/execute).
- Generalised to WIDTH-bit operands, with registered operands, result and status flags.
- Adds a multi-cycle shift-add multiplier with a busy/done handshake.
- Adds illegal-opcode detection.
- Sits between the debounced button/switch front-end and the LED/7-segment display drivers.

Parameters:
WIDTH, 8, operand width in bits (>=2)
OPW, 4, opcode field width

Ports:
clk_50M  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
din  input  WIDTH  operand data (switches)
op  input  OPW  opcode (switches), sampled on the exec event
ld_a  input  1  level request: load din into A (debounced pb1)
ld_b  input  1  level request: load din into B (debounced pb2)
exec  input  1  level request: execute op (debounced pb3)
result  output  2*WIDTH  registered result
flag_c  output  1  carry/borrow/shift-out/high-half-nonzero
flag_z  output  1  result == 0
flag_n  output  1  sign bit of result
flag_v  output  1  signed overflow
busy  output  1  multiply in progress
done  output  1  one-cycle pulse when result/flags are updated
err  output  1  sticky illegal-opcode flag

Behaviour:
- Reset (synchronous, active-high): A, B, result, all flags, busy, done and err are 0; FSM goes to IDLE.
- Edge-detect registers load the current ld_a/ld_b/exec levels during reset, so a button held across reset release generates no event.
- Events: rising edge only (level & ~level_q). A button held for N cycles produces exactly one event.
- ld_a/ld_b events load din into A/B at that clock edge. Simultaneous ld_a and ld_b load both.
- exec event in the same cycle as a load: the operation uses the pre-load A/B values; the load still takes effect.
- FSM states: IDLE, MUL.
- IDLE, exec event with a single-cycle op: result and flags update at that edge; done=1 for the following cycle.
- Single-cycle ops write result[2W-1:W]=0. flag_n = result[W-1].
- Opcodes and flags:
  - 0 NOP: nothing updates, no done.
  - 1 ADD: A+B; c=carry out; v=signed overflow.
  - 2 SUB: A-B; c=borrow (A<B unsigned); v=signed overflow.
  - 3 NEG: -A (two's complement); c=(A!=0); v=(A==100..0).
  - 4 AND, 5 OR, 6 XOR, 7 NOT A: c=0, v=0.
  - 8 SHL A by 1: c=A[W-1]. 9 SHR A (logical) by 1: c=A[0]. v=0 for both.
  - 10 MUL: unsigned A*B, full 2W-bit result; see below.
  - 11..max: illegal; err is set (sticky until reset); result/flags unchanged; no done.
- MUL:
  - exec edge at clock edge 0 latches multiplicand/multiplier, enters MUL, busy=1.
  - One shift-add iteration per cycle; WIDTH iterations at edges 1..WIDTH.
  - At edge WIDTH: result written; busy=0; done=1 for one cycle; return to IDLE.
  - Flags: c = (result[2W-1:W] != 0); n = 0; v = 0; z over the full 2W bits.
- While busy: ld_a, ld_b and exec events are dropped (not queued); A/B unchanged; err unaffected. Edge-detect registers keep tracking, so a button held across busy fires nothing afterwards.
- rst asserted mid-MUL: partial product discarded; all outputs return to reset values on the next edge.
- done is never asserted in two consecutive cycles.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_NOP..OP_MUL, OP_LAST=10), FSM state typedef {IDLE, MUL}, iteration-counter width function ($clog2(WIDTH+1)).
- Sub-module edge_pulse: 1-bit rising-edge detector with reset-load-current-level behaviour; instantiated 3x for ld_a, ld_b, exec.
- Iteration counter and shift-add datapath stay inline.

Test Plan:
1. WIDTH=8. rst 5 cycles, ld_a edge with din=255, ld_b edge with din=15, exec op=1 -> result=0x000E, c=1, z=0, n=0, v=0; done high exactly one cycle after the exec edge.
2. Same A/B, ops 2,3,4,5,6 in turn:
   - SUB: 0x00F0, c=0, n=1.
   - NEG: 0x0001, c=1.
   - AND: 0x000F.
   - OR: 0x00FF, n=1.
   - XOR: 0x00F0.
   - Every op produces one done pulse each.
3. exec op=10 -> busy=1 for 8 cycles; done after the 8th edge; result=0x0EF1, c=1, z=0. An exec edge injected mid-busy is ignored (exactly one done total).
4. exec held high for 20 cycles with op=1 -> exactly one done. ld_a held through rst release -> A stays 0.
5. exec op=12 -> err=1, result unchanged, no done. Next legal op still executes with err remaining 1. rst clears err.
6. Start MUL, assert rst at iteration 4 -> next cycle busy=0, result=0, done never pulses. A fresh ld/exec sequence then works normally.
